// File: rtl/link_table_requester_pkg.sv
// Shared definitions for the link-table requester.
// Order type codes are the same encodings the linked-list table manager uses
// on order_type, so commands pass through to the manager unchanged.
// The FSM state encoding is shared here so benches and debug logic can decode it.
package link_table_requester_pkg;

   localparam logic [1:0] APPE = 2'd0;
   localparam logic [1:0] DELE = 2'd1;
   localparam logic [1:0] CHAG = 2'd2;
   localparam logic [1:0] READ = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } req_state_e;

endpackage

// File: rtl/link_table_cmd_fifo.sv
// Host command FIFO for the link-table requester.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   i_push       : write i_push_data (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_full       : occupancy == depth, combinational from the counter
//   o_empty      : occupancy == 0
//   o_head       : oldest entry, read straight from the storage registers
module link_table_cmd_fifo
   import link_table_requester_pkg::*;
#(
   parameter int WIDTH      = 42,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   // Count never exceeds DEPTH, so its MSB alone marks full.
   assign o_full    = r_count[DEPTH_LOG2];
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage holds data only; stale entries are unreachable after reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/link_table_requester.sv
// Initiator for the linked-list table manager's order/dout protocol.
// Host commands are queued in a small FIFO, issued one at a time as orders,
// and each manager result (or a watchdog timeout) is returned on the response port.
// Ports:
//   cmd_*   : host command in (cmd_busy = FIFO full)
//   order_* : order out to the manager
//   dout_*  : result in from the manager
//   resp_*  : completion out to the host (resp_err on failure or timeout)
//   timeout_flag : sticky timeout indicator, err_count : saturating error count
module link_table_requester
   import link_table_requester_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int TABLE_WIDTH    = 8,
   parameter int CMD_DEPTH_LOG2 = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_busy,
   input  logic [1:0]             cmd_type,
   input  logic [TABLE_WIDTH-1:0] cmd_table,
   input  logic [ADDR_WIDTH-1:0]  cmd_node,
   input  logic [DATA_WIDTH-1:0]  cmd_data,
   output logic                   order_valid,
   input  logic                   order_busy,
   output logic [1:0]             order_type,
   output logic [TABLE_WIDTH-1:0] order_table,
   output logic [ADDR_WIDTH-1:0]  order_node,
   output logic [DATA_WIDTH-1:0]  order_data,
   input  logic                   dout_valid,
   output logic                   dout_busy,
   input  logic [DATA_WIDTH-1:0]  dout_data,
   output logic                   resp_valid,
   input  logic                   resp_busy,
   output logic [1:0]             resp_type,
   output logic [DATA_WIDTH-1:0]  resp_data,
   output logic                   resp_err,
   output logic                   timeout_flag,
   output logic [7:0]             err_count
);

   localparam int CMD_W = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   req_state_e             r_state, w_state_nxt;
   logic                   w_pop, w_full, w_empty;
   logic [CMD_W-1:0]       w_head;
   logic                   w_order_xfer, w_dout_xfer, w_resp_xfer, w_timeout;

   logic                   r_order_valid;
   logic [1:0]             r_order_type;
   logic [TABLE_WIDTH-1:0] r_order_table;
   logic [ADDR_WIDTH-1:0]  r_order_node;
   logic [DATA_WIDTH-1:0]  r_order_data;
   logic                   r_dout_busy;
   logic                   r_resp_valid;
   logic [1:0]             r_resp_type;
   logic [DATA_WIDTH-1:0]  r_resp_data;
   logic                   r_resp_err;
   logic                   r_timeout_flag;
   logic [7:0]             r_err_count;
   logic [WD_W-1:0]        r_wdog;
   logic                   r_drain_dout;   // late dout has been absorbed
   logic                   r_drain_resp;   // timeout response has been taken

   // Manager reports 1 for success, 0 for fatal; read data is passed through.
   function automatic logic is_fail(input logic [1:0] ty, input logic [DATA_WIDTH-1:0] d);
      return (ty != READ) && (d == '0);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   link_table_cmd_fifo #(
      .WIDTH      (CMD_W),
      .DEPTH_LOG2 (CMD_DEPTH_LOG2)
   ) u_cmd_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (cmd_valid),
      .i_push_data ({cmd_type, cmd_table, cmd_node, cmd_data}),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   assign cmd_busy     = w_full;
   assign w_order_xfer = r_order_valid && !order_busy;
   assign w_dout_xfer  = dout_valid && !r_dout_busy;
   assign w_resp_xfer  = r_resp_valid && !resp_busy;
   assign w_timeout    = (r_wdog == WD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: if (w_order_xfer) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            // A result arriving in the timeout cycle is a normal completion.
            if (w_dout_xfer)    w_state_nxt = ST_RESP;
            else if (w_timeout) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Leave only when both the stale result and our response are gone,
            // so the manager never sees a second outstanding order.
            if ((r_drain_dout || w_dout_xfer) && (r_drain_resp || w_resp_xfer))
               w_state_nxt = ST_IDLE;
         end
         ST_RESP: if (w_resp_xfer) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_order_valid  <= 1'b0;
         r_order_type   <= '0;
         r_order_table  <= '0;
         r_order_node   <= '0;
         r_order_data   <= '0;
         r_dout_busy    <= 1'b1;
         r_resp_valid   <= 1'b0;
         r_resp_type    <= '0;
         r_resp_data    <= '0;
         r_resp_err     <= 1'b0;
         r_timeout_flag <= 1'b0;
         r_err_count    <= '0;
         r_wdog         <= '0;
         r_drain_dout   <= 1'b0;
         r_drain_resp   <= 1'b0;
      end else begin
         if (w_resp_xfer) begin
            r_resp_valid <= 1'b0;
            if (r_resp_err) r_err_count <= sat_inc(r_err_count);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  {r_order_type, r_order_table, r_order_node, r_order_data} <= w_head;
                  r_order_valid <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (w_order_xfer) begin
                  r_order_valid <= 1'b0;
                  r_dout_busy   <= 1'b0;
                  r_wdog        <= '0;
               end
            end
            ST_WAIT: begin
               r_wdog <= r_wdog + 1'b1;
               if (w_dout_xfer) begin
                  r_dout_busy  <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_resp_type  <= r_order_type;
                  r_resp_data  <= dout_data;
                  r_resp_err   <= is_fail(r_order_type, dout_data);
               end else if (w_timeout) begin
                  // dout_busy stays low so the late result can be drained.
                  r_resp_valid   <= 1'b1;
                  r_resp_type    <= r_order_type;
                  r_resp_data    <= '0;
                  r_resp_err     <= 1'b1;
                  r_timeout_flag <= 1'b1;
                  r_drain_dout   <= 1'b0;
                  r_drain_resp   <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (w_dout_xfer) begin
                  r_dout_busy  <= 1'b1;
                  r_drain_dout <= 1'b1;
               end
               if (w_resp_xfer) r_drain_resp <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign order_valid  = r_order_valid;
   assign order_type   = r_order_type;
   assign order_table  = r_order_table;
   assign order_node   = r_order_node;
   assign order_data   = r_order_data;
   assign dout_busy    = r_dout_busy;
   assign resp_valid   = r_resp_valid;
   assign resp_type    = r_resp_type;
   assign resp_data    = r_resp_data;
   assign resp_err     = r_resp_err;
   assign timeout_flag = r_timeout_flag;
   assign err_count    = r_err_count;

endmodule
